prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_csum.sv | 36 +++
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared constants and FSM state encoding for the program loader.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_csum.sv
`default_nettype none
// ============================================================================
//  Module      : loader_csum
//  Description : Clearable modulo-2^DATA_W byte accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module loader_csum
    import loader_pkg::*;
#(
    parameter int DATA_W = loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    // Clear has priority so a new image never inherits the previous total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_din;
        end
    end

    assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Freezes the CPU at step 0, streams an image into program RAM,
//                reads it back to verify the checksum, then restarts the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = loader_pkg::ADDR_W,
    parameter int DATA_W = loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_csum,
    input  logic              cpu_t0,
    output logic              cpu_hold,
    output logic              pc_clr,
    output logic              own_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit lets the counter reach 2^ADDR_W without wrapping to 0.
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'((1 << ADDR_W) - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_n;
    logic [DATA_W-1:0] r_csum;
    logic              r_re_d;
    logic              r_ld_ready;
    logic              r_cpu_hold;
    logic              r_pc_clr;
    logic              r_own_ram;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_beat;
    logic              w_last_beat;
    logic              w_rd_active;
    logic [DATA_W-1:0] w_wr_sum;
    logic [DATA_W-1:0] w_rd_sum;
    logic [DATA_W-1:0] w_rd_final;
    logic              w_mismatch;

    assign w_beat      = (r_state == ST_LOAD) && r_ld_ready && ld_valid;
    assign w_last_beat = w_beat && (ld_last || (r_cnt == c_LAST_IDX));
    assign w_rd_active = (r_state == ST_VERIFY) && (r_rd_cnt != r_n);

    // Write and read strobes are decoded from mutually exclusive states.
    assign ram_we    = w_beat;
    assign ram_re    = w_rd_active;
    assign ram_wdata = w_beat ? ld_data : '0;
    assign ram_addr  = w_beat      ? r_cnt[ADDR_W-1:0]    :
                       w_rd_active ? r_rd_cnt[ADDR_W-1:0] : '0;

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_wr_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state == ST_HOLD),
        .i_en  (w_beat),
        .i_din (ld_data),
        .o_sum (w_wr_sum)
    );

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_rd_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state == ST_LOAD),
        .i_en  (r_re_d),
        .i_din (ram_rdata),
        .o_sum (w_rd_sum)
    );

    // The last read-back byte arrives in the final VERIFY cycle; fold it in here.
    assign w_rd_final = w_rd_sum + ram_rdata;
    assign w_mismatch = (w_rd_final != r_csum) || (w_wr_sum != r_csum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_cnt   <= '0;
            r_n        <= '0;
            r_csum     <= '0;
            r_re_d     <= 1'b0;
            r_ld_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_pc_clr   <= 1'b0;
            r_own_ram  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_re_d   <= w_rd_active;
            r_pc_clr <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_state    <= ST_HOLD;
                        r_busy     <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_err      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cpu_t0) begin
                        r_state    <= ST_LOAD;
                        r_own_ram  <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state    <= ST_VERIFY;
                            r_ld_ready <= 1'b0;
                            r_csum     <= ld_csum;
                            r_n        <= r_cnt + 1'b1;
                            r_rd_cnt   <= '0;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (r_rd_cnt == r_n) begin
                        r_state   <= ST_RELEASE;
                        r_pc_clr  <= 1'b1;
                        r_done    <= 1'b1;
                        r_own_ram <= 1'b0;
                        if (w_mismatch) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state    <= ST_IDLE;
                    r_cpu_hold <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_ready = r_ld_ready;
    assign cpu_hold = r_cpu_hold;
    assign pc_clr   = r_pc_clr;
    assign own_ram  = r_own_ram;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire
